// File: rtl/survivor_regex.sv
// rtl/survivor_regex.sv - register-exchange survivor path memory for a 4-state Viterbi decoder
//
// Purpose:
//   Holds one survivor sequence per trellis state and exchanges them in parallel
//   on every trellis step, using the ACS decision bits to choose each state's
//   predecessor. Once DEPTH steps have been seen, it emits one decoded bit per
//   step. The bit is taken from the oldest position of the best state's survivor.
//
// Ports:
//   clk         in   rising-edge clock, at most one trellis step per cycle
//   reset       in   synchronous active-high reset
//   clear       in   synchronous frame restart, same effect as reset
//   in_valid    in   dec_in / best_state carry a trellis step this cycle
//   dec_in      in   [3:0] ACS decision per state (predecessor select)
//   best_state  in   [1:0] min-metric state after this step
//   out_valid   out  one-cycle pulse, out_bit is valid
//   out_bit     out  decoded information bit
//   filled      out  survivor window full, steady-state decoding
module survivor_regex #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [3:0] dec_in,
  input  logic [1:0] best_state,
  output logic       out_valid,
  output logic       out_bit,
  output logic       filled
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // The oldest survivor bit only ever feeds out_bit in the same step, so only
  // DEPTH-1 bits of history are kept. The full DEPTH-bit word exists in nsurv.
  logic [DEPTH-2:0] surv  [4];
  logic [DEPTH-1:0] nsurv [4];

  logic [CW-1:0] fill_cnt;
  logic [CW:0]   fill_inc;
  logic [CW-1:0] fill_nxt;
  logic          last_step;

  // Parallel exchange: each state takes its predecessor's pre-update history
  // and appends the bit implied by entering this state (state MSB).
  for (genvar g = 0; g < 4; g++) begin : g_exch
    localparam logic [1:0] N = 2'(g);
    logic [1:0] pred;
    assign pred     = {N[0], dec_in[g]};
    assign nsurv[g] = {surv[pred], N[1]};
  end

  always_comb begin
    fill_inc  = {1'b0, fill_cnt} + 1'b1;
    last_step = (fill_inc >= DEPTH_W);
    fill_nxt  = fill_cnt;
    if ({1'b0, fill_cnt} < DEPTH_W) begin
      fill_nxt = fill_inc[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int n = 0; n < 4; n++) begin
        surv[n] <= '0;
      end
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      filled    <= 1'b0;
    end else if (in_valid) begin
      for (int n = 0; n < 4; n++) begin
        surv[n] <= nsurv[n][DEPTH-2:0];
      end
      fill_cnt  <= fill_nxt;
      filled    <= ({1'b0, fill_nxt} == DEPTH_W);
      out_bit   <= nsurv[best_state][DEPTH-1];
      out_valid <= last_step;
    end else begin
      // best_state is not looked at here, so an X on it while idle stays out.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_survivor_regex.sv
// tb/tb_survivor_regex.sv - directed self-checking bench for survivor_regex
module tb_survivor_regex;

  localparam int DEPTH = 8;
  localparam int NSTEP = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] dec_in = 4'h0;
  logic [1:0] best_state = 2'd0;
  logic       out_valid;
  logic       out_bit;
  logic       filled;

  int checks = 0;
  int errors = 0;

  logic [NSTEP-1:0] u;
  logic [NSTEP-1:0] u2;
  logic             out_q[$];

  survivor_regex #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .dec_in     (dec_in),
    .best_state (best_state),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .filled     (filled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after the active edge, collect outputs.
  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] b,
                       input logic rst, input logic clr);
    @(negedge clk);
    in_valid   = v;
    dec_in     = d;
    best_state = b;
    reset      = rst;
    clear      = clr;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) out_q.push_back(out_bit);
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
    out_q.delete();
  endtask

  // Ideal ACS along the true path: state s_t = {u_t, u_t-1}, whose predecessor
  // bit is u_t-2. Decisions of off-path states are random and must not matter.
  task automatic step_true(input logic [NSTEP-1:0] seq, input int t, input logic clr);
    logic       ut, u1, u2b;
    logic [1:0] s;
    logic [3:0] d;
    ut  = seq[t];
    u1  = 1'b0;
    u2b = 1'b0;
    if (t >= 1) u1 = seq[t-1];
    if (t >= 2) u2b = seq[t-2];
    s    = {ut, u1};
    d    = 4'($urandom);
    d[s] = u2b;
    drive(1'b1, d, s, 1'b0, clr);
  endtask

  task automatic check_seq(input string tag, input logic [NSTEP-1:0] seq);
    check({tag, "_count"}, out_q.size(), NSTEP - DEPTH + 1);
    for (int k = 0; k < out_q.size() && k < NSTEP; k++) begin
      check(tag, {31'd0, out_q[k]}, {31'd0, seq[k]});
    end
  endtask

  initial begin
    for (int i = 0; i < NSTEP; i++) begin
      u[i]  = 1'($urandom);
      u2[i] = 1'($urandom);
    end

    // T1: reset held two cycles with random activity on the inputs
    drive(1'b1, 4'($urandom), 2'($urandom), 1'b1, 1'b0);
    drive(1'b1, 4'($urandom), 2'($urandom), 1'b1, 1'b0);
    check("t1_out_valid", {31'd0, out_valid}, 32'd0);
    check("t1_out_bit",   {31'd0, out_bit},   32'd0);
    check("t1_filled",    {31'd0, filled},    32'd0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b1, 4'($urandom), 2'($urandom), 1'b0, 1'b0);
      check("t1_no_out", {31'd0, out_valid}, 32'd0);
      check("t1_not_filled", {31'd0, filled}, 32'd0);
    end

    // T2: all-ones decisions, best state 3
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 4'b1111, 2'd3, 1'b0, 1'b0);
      check("t2_out_valid", {31'd0, out_valid}, {31'd0, (i >= DEPTH)});
      check("t2_filled",    {31'd0, filled},    {31'd0, (i >= DEPTH)});
      if (i >= DEPTH) check("t2_out_bit", {31'd0, out_bit}, 32'd1);
    end
    check("t2_count", out_q.size(), 13);

    // T3: all-zero decisions, then one step ending in state 2
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
      if (i >= DEPTH) check("t3_out_bit", {31'd0, out_bit}, 32'd0);
    end
    check("t3_count", out_q.size(), 5);
    drive(1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    check("t3_bs2_valid", {31'd0, out_valid}, 32'd1);
    check("t3_bs2_bit",   {31'd0, out_bit},   32'd0);

    // T4: ideal decisions along a random path, back-to-back
    do_reset();
    for (int t = 0; t < NSTEP; t++) step_true(u, t, 1'b0);
    check_seq("t4_bit", u);

    // T5: same path with idle gaps carrying X on the step inputs
    do_reset();
    for (int t = 0; t < NSTEP; t++) begin
      step_true(u, t, 1'b0);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        drive(1'b0, 4'bxxxx, 2'bxx, 1'b0, 1'b0);
        check("t5_idle_valid", {31'd0, out_valid}, 32'd0);
      end
    end
    check_seq("t5_bit", u);

    // T6: clear mid-frame with a concurrent step, then a fresh frame
    do_reset();
    for (int t = 0; t < 30; t++) step_true(u, t, 1'b0);
    step_true(u, 30, 1'b1);
    check("t6_clr_valid",  {31'd0, out_valid}, 32'd0);
    check("t6_clr_bit",    {31'd0, out_bit},   32'd0);
    check("t6_clr_filled", {31'd0, filled},    32'd0);
    out_q.delete();
    for (int t = 0; t < NSTEP; t++) begin
      step_true(u2, t, 1'b0);
      if (t < DEPTH - 1) check("t6_no_out", {31'd0, out_valid}, 32'd0);
    end
    check_seq("t6_bit", u2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
